alu_issue_ctrl: RTL and testbench

- Sequential front/back-end for the combinational ALU.
- Accepts operation requests on a valid/ready channel and registers them onto the ALU input bus.
- Holds the operands for a programmable settle time, then captures the ALU result and flags into a small response FIFO, which it drains over a valid/ready response channel.
- Sits between the testbench/pipeline request source and the ALU DUT; it feeds the ALU input channel and consumes the ALU output channel.

---
 rtl/alu_issue_ctrl_pkg.sv | 20 ++
 rtl/alu_issue_ctrl_if.sv | 22 ++
 rtl/alu_issue_ctrl_fifo.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 90 +++++++++
 tb/tb_alu_issue_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller: opcode and flag
// widths, flag bit positions, FSM state encoding and the response record.
package alu_pkg;
    localparam int OPCODE_W = 4;
    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_N   = 3;
    localparam int FLAG_DBZ = 4;
    localparam int FLAGS_W  = 5;
    localparam int ALU_W    = 32;

    typedef enum logic {IDLE, EXEC} issue_state_e;

    // Response record at the default 32-bit ALU width
    typedef struct packed {
        logic [ALU_W-1:0]   result;
        logic [FLAGS_W-1:0] flags;
    } alu_rsp_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and response handshake channels of the ALU issue controller.
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
    import alu_pkg::*;
    logic                req_valid;
    logic                req_ready;
    logic [WIDTH-1:0]    req_a;
    logic [WIDTH-1:0]    req_b;
    logic [OPCODE_W-1:0] req_opcode;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_result;
    logic [FLAGS_W-1:0]  rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
    modport master (
        output req_valid, req_a, req_b, req_opcode, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// First-word-fall-through response FIFO with occupancy count; a pop is only
// honoured while the head is valid, so an empty FIFO never underflows.
module alu_rsp_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_ready,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          pop;

    assign head_valid = (count != '0);
    assign head_data  = mem[rptr];
    assign pop        = head_valid && pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller around a combinational ALU: registers one request
// onto the ALU inputs, waits SETTLE cycles, then queues result and flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_issue_ctrl_if.slave         bus,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [OPCODE_W-1:0]     alu_opcode,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_zero,
    input  logic                    alu_carry,
    input  logic                    alu_overflow,
    input  logic                    alu_negative,
    input  logic                    alu_div_by_zero,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  rsp_count
);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    issue_state_e         state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 accept, capture;
    logic [FLAGS_W-1:0]   flags;

    // Only one op is ever in flight, so a free slot at accept guarantees room at capture
    assign bus.req_ready = rst_n && (state == IDLE) && (rsp_count < CW'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign capture       = (state == EXEC) && (cnt == '0);
    assign busy          = (state == EXEC);

    always_comb begin
        flags           = '0;
        flags[FLAG_Z]   = alu_zero;
        flags[FLAG_C]   = alu_carry;
        flags[FLAG_V]   = alu_overflow;
        flags[FLAG_N]   = alu_negative;
        flags[FLAG_DBZ] = alu_div_by_zero;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nxt = EXEC;
                cnt_nxt   = CNT_W'(SETTLE - 1);
            end
            EXEC: if (cnt == '0) state_nxt = IDLE;
                  else           cnt_nxt   = cnt - 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                alu_a      <= bus.req_a;
                alu_b      <= bus.req_b;
                alu_opcode <= bus.req_opcode;
            end
        end
    end

    alu_rsp_fifo #(.W(WIDTH + FLAGS_W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (capture),
        .push_data  ({alu_result, flags}),
        .pop_ready  (bus.rsp_ready),
        .head_valid (bus.rsp_valid),
        .head_data  ({bus.rsp_result, bus.rsp_flags}),
        .count      (rsp_count)
    );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at SETTLE=1 and one at
// SETTLE=3, each driving a behavioural ALU stub.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(32)) if1 ();
    alu_issue_ctrl_if #(.WIDTH(32)) if3 ();

    logic [31:0] a1, b1, a3, b3;
    logic [3:0]  op1, op3;
    logic        busy1, busy3;
    logic [2:0]  cnt1, cnt3;
    alu_rsp_t    m1, m3;

    function automatic alu_rsp_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        alu_rsp_t r;
        logic c, v, d;
        c = 1'b0; v = 1'b0; d = 1'b0;
        case (op)
            4'h0: begin {c, r.result} = {1'b0, a} + {1'b0, b};
                        v = ~(a[31] ^ b[31]) & (r.result[31] ^ a[31]); end
            4'h1: begin {c, r.result} = {1'b0, a} - {1'b0, b};
                        v = (a[31] ^ b[31]) & (r.result[31] ^ a[31]); end
            4'h3: begin d = (b == 0); r.result = d ? 32'd0 : a / b; end
            default: r.result = a & b;
        endcase
        r.flags = {d, r.result[31], v, c, r.result == 32'd0};
        return r;
    endfunction

    assign m1 = alu_model(a1, b1, op1);
    assign m3 = alu_model(a3, b3, op3);

    alu_issue_ctrl #(.WIDTH(32), .DEPTH(4), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave),
        .alu_a(a1), .alu_b(b1), .alu_opcode(op1), .alu_result(m1.result),
        .alu_zero(m1.flags[0]), .alu_carry(m1.flags[1]), .alu_overflow(m1.flags[2]),
        .alu_negative(m1.flags[3]), .alu_div_by_zero(m1.flags[4]),
        .busy(busy1), .rsp_count(cnt1));

    alu_issue_ctrl #(.WIDTH(32), .DEPTH(4), .SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave),
        .alu_a(a3), .alu_b(b3), .alu_opcode(op3), .alu_result(m3.result),
        .alu_zero(m3.flags[0]), .alu_carry(m3.flags[1]), .alu_overflow(m3.flags[2]),
        .alu_negative(m3.flags[3]), .alu_div_by_zero(m3.flags[4]),
        .busy(busy3), .rsp_count(cnt3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to the SETTLE=1 instance; returns #1 after the accept edge
    task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n = 0;
        while (!if1.req_ready && n < 20) begin tick(); n++; end
        chk("issue_ready", if1.req_ready, 1'b1);
        if1.req_valid = 1'b1; if1.req_a = a; if1.req_b = b; if1.req_opcode = op;
        tick();
        if1.req_valid = 1'b0;
    endtask

    task automatic pop1();
        if1.rsp_ready = 1'b1;
        tick();
        if1.rsp_ready = 1'b0;
    endtask

    initial begin
        int sent, got, k;
        if1.req_valid = 0; if1.req_a = 0; if1.req_b = 0; if1.req_opcode = 0; if1.rsp_ready = 0;
        if3.req_valid = 0; if3.req_a = 0; if3.req_b = 0; if3.req_opcode = 0; if3.rsp_ready = 0;

        // Reset state
        #12;
        chk("rst_req_ready", if1.req_ready, 1'b0);
        chk("rst_rsp_valid", if1.rsp_valid, 1'b0);
        chk("rst_count", cnt1, 3'd0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_alu_a", a1, 32'd0);
        chk("rst_result", {if1.rsp_result, if1.rsp_flags}, 37'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_ready", if1.req_ready, 1'b1);

        // Single ADD 5+7
        issue1(32'd5, 32'd7, 4'h0);
        chk("add_alu_a", a1, 32'd5);
        chk("add_busy", busy1, 1'b1);
        chk("add_ready_low", if1.req_ready, 1'b0);
        chk("add_rsp_early", if1.rsp_valid, 1'b0);
        tick();
        chk("add_rsp_valid", if1.rsp_valid, 1'b1);
        chk("add_result", if1.rsp_result, 32'd12);
        chk("add_flags", if1.rsp_flags, 5'b00000);
        chk("add_busy_done", busy1, 1'b0);
        chk("add_alu_hold", a1, 32'd5);
        pop1();
        chk("add_popped", cnt1, 3'd0);

        // Flag capture
        issue1(32'hFFFF_FFFF, 32'd1, 4'h0);
        tick();
        chk("zc_result", if1.rsp_result, 32'd0);
        chk("zc_flags", if1.rsp_flags, 5'b00011);
        pop1();
        issue1(32'd10, 32'd0, 4'h3);
        tick();
        chk("dbz_flag", if1.rsp_flags[FLAG_DBZ], 1'b1);
        pop1();

        // Backpressure: 6 offered, 4 fit
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            if (if1.req_ready && sent < 6) begin
                if1.req_valid = 1'b1; if1.req_a = 32'd100 + sent; if1.req_b = 32'd10;
                if1.req_opcode = 4'h0; sent++;
            end else if1.req_valid = 1'b0;
            tick();
        end
        if1.req_valid = 1'b0;
        chk("bp_accepted", sent, 4);
        chk("bp_count", cnt1, 3'd4);
        chk("bp_ready_low", if1.req_ready, 1'b0);
        tick();
        chk("bp_head_stable", if1.rsp_result, 32'd110);
        pop1();
        chk("bp_count_after_pop", cnt1, 3'd3);
        chk("bp_ready_again", if1.req_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            chk("bp_drain_order", if1.rsp_result, 32'd110 + i);
            pop1();
        end
        chk("bp_empty", if1.rsp_valid, 1'b0);

        // Streaming with consumer always ready
        if1.rsp_ready = 1'b1;
        sent = 0; got = 0; k = 0;
        while (got < 10 && k < 60) begin
            if (cnt1 > 3'd1) chk("stream_count_max", cnt1, 3'd1);
            if (if1.rsp_valid) begin
                chk("stream_order", if1.rsp_result, 32'd2 * got);
                got++;
            end
            if (if1.req_ready && sent < 10) begin
                if1.req_valid = 1'b1; if1.req_a = sent; if1.req_b = sent; sent++;
            end else if1.req_valid = 1'b0;
            tick();
            k++;
        end
        chk("stream_got", got, 10);
        if1.req_valid = 1'b0; if1.rsp_ready = 1'b0;

        // SETTLE=3 timing on the second instance
        if3.req_valid = 1'b1; if3.req_a = 32'd20; if3.req_b = 32'd3; if3.req_opcode = 4'h1;
        tick();
        if3.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s3_alu_a", a3, 32'd20);
            chk("s3_ready_low", if3.req_ready, 1'b0);
            chk("s3_no_rsp", if3.rsp_valid, 1'b0);
            tick();
        end
        chk("s3_rsp_valid", if3.rsp_valid, 1'b1);
        chk("s3_result", if3.rsp_result, 32'd17);
        chk("s3_busy_done", busy3, 1'b0);

        // Reset mid-EXEC with two responses queued
        issue1(32'd1, 32'd1, 4'h0); tick();
        issue1(32'd2, 32'd2, 4'h0); tick();
        chk("mr_queued", cnt1, 3'd2);
        issue1(32'd3, 32'd3, 4'h0);
        chk("mr_in_exec", busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_count", cnt1, 3'd0);
        chk("mr_rsp_valid", if1.rsp_valid, 1'b0);
        chk("mr_busy", busy1, 1'b0);
        chk("mr_alu_a", a1, 32'd0);
        chk("mr_req_ready", if1.req_ready, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        chk("mr_no_stale", if1.rsp_valid, 1'b0);
        issue1(32'd9, 32'd4, 4'h0);
        tick();
        chk("mr_next_result", if1.rsp_result, 32'd13);
        chk("mr_next_count", cnt1, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
